// File: rtl/button_press_arbiter.sv
// Round-robin arbiter that buffers button press pulses in saturating
// per-button counters and issues them one at a time over valid/ready.
module button_press_arbiter #(
  parameter int NUM_BUTTONS   = 3,
  parameter int PENDING_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_BUTTONS-1:0] press,
  output logic                   grant_valid,
  output logic [NUM_BUTTONS-1:0] grant,
  input  logic                   grant_ready,
  output logic                   pending_any,
  output logic [NUM_BUTTONS-1:0] overflow,
  input  logic                   overflow_clr
);

  localparam int PTR_W = $clog2(NUM_BUTTONS);
  localparam logic [PENDING_WIDTH-1:0] PMAX = {PENDING_WIDTH{1'b1}};

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                   state;
  logic [PENDING_WIDTH-1:0] pending   [NUM_BUTTONS];
  logic [PENDING_WIDTH-1:0] pend_next [NUM_BUTTONS];
  logic [PTR_W-1:0]         ptr;
  logic [PTR_W-1:0]         gidx;
  logic [NUM_BUTTONS-1:0]   ovf_set;
  logic [NUM_BUTTONS-1:0]   hs_vec;
  logic [NUM_BUTTONS-1:0]   sel;
  logic [PTR_W-1:0]         sel_idx;
  logic                     found;
  int                       j;

  assign hs_vec = (grant_valid && grant_ready) ? grant : '0;

  // A same-cycle press and handshake on one button cancel out, even at max.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      pend_next[i] = pending[i];
      if (press[i] && enable) begin
        if (!hs_vec[i]) begin
          if (pending[i] == PMAX) ovf_set[i] = 1'b1;
          else pend_next[i] = pending[i] + 1'b1;
        end
      end else if (hs_vec[i]) begin
        pend_next[i] = pending[i] - 1'b1;
      end
    end
  end

  always_comb begin
    pending_any = 1'b0;
    for (int i = 0; i < NUM_BUTTONS; i++)
      pending_any = pending_any | (pending[i] != '0);
  end

  // Search upward from ptr with wrap-around for the first pending button.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_BUTTONS; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_BUTTONS) j = j - NUM_BUTTONS;
      if (!found && pending[j] != '0) begin
        found   = 1'b1;
        sel[j]  = 1'b1;
        sel_idx = PTR_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant       <= '0;
      gidx        <= '0;
      ptr         <= '0;
      overflow    <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) pending[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) pending[i] <= pend_next[i];
      overflow <= (overflow_clr ? '0 : overflow) | ovf_set;
      unique case (state)
        IDLE: begin
          if (enable && pending_any) begin
            grant       <= sel;
            gidx        <= sel_idx;
            grant_valid <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (grant_ready) begin
            grant_valid <= 1'b0;
            grant       <= '0;
            if (gidx == PTR_W'(NUM_BUTTONS - 1)) ptr <= '0;
            else ptr <= gidx + PTR_W'(1);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_arbiter.sv
// Directed bench for button_press_arbiter: reset, latency, round-robin
// order, saturation, backpressure and simultaneous press/handshake.
module tb_button_press_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] press;
  logic       grant_valid;
  logic [2:0] grant;
  logic       grant_ready;
  logic       pending_any;
  logic [2:0] overflow;
  logic       overflow_clr;

  int vectors = 0;
  int errors  = 0;

  button_press_arbiter #(.NUM_BUTTONS(3), .PENDING_WIDTH(3)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .press(press),
    .grant_valid(grant_valid),
    .grant(grant),
    .grant_ready(grant_ready),
    .pending_any(pending_any),
    .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    press = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; press = 3'b111;
    grant_ready = 1'b1; overflow_clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++;
      if ({grant_valid, grant, pending_any, overflow} !== 8'b0) begin
        errors++;
        $display("FAIL reset_out got v=%b g=%b pa=%b ov=%b want all 0",
                 grant_valid, grant, pending_any, overflow);
      end
    end
    rst = 1'b0; press = '0;
    step();
    vectors++;
    if (pending_any !== 1'b0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got pa=%b v=%b want 0 0",
               pending_any, grant_valid);
    end
  endtask

  task automatic test_single();
    enable = 1'b1; grant_ready = 1'b1;
    press = 3'b010;
    step();
    press = '0;
    vectors++;
    if (grant_valid !== 1'b0 || pending_any !== 1'b1) begin
      errors++;
      $display("FAIL single_t1 got v=%b pa=%b want 0 1",
               grant_valid, pending_any);
    end
    step();
    vectors++;
    if (grant_valid !== 1'b1 || grant !== 3'b010) begin
      errors++;
      $display("FAIL single_t2 got v=%b g=%b want 1 010",
               grant_valid, grant);
    end
    step();
    vectors++;
    if (grant_valid !== 1'b0 || grant !== 3'b000 || pending_any !== 1'b0) begin
      errors++;
      $display("FAIL single_t3 got v=%b g=%b pa=%b want 0 000 0",
               grant_valid, grant, pending_any);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [8];
    exp_g = '{3'b000, 3'b001, 3'b000, 3'b010,
              3'b000, 3'b100, 3'b000, 3'b000};
    do_reset();
    enable = 1'b1; grant_ready = 1'b1;
    press = 3'b111;
    for (int k = 0; k < 8; k++) begin
      step();
      press = '0;
      vectors++;
      if (grant_valid !== (exp_g[k] != 3'b000) || grant !== exp_g[k]) begin
        errors++;
        $display("FAIL rr_step%0d got v=%b g=%b want g=%b",
                 k, grant_valid, grant, exp_g[k]);
      end
    end
    // Pointer back at 0: 101 must give 001 then 100.
    press = 3'b101;
    step();
    press = '0;
    step();
    vectors++;
    if (grant_valid !== 1'b1 || grant !== 3'b001) begin
      errors++;
      $display("FAIL rr_ptr0 got v=%b g=%b want 1 001", grant_valid, grant);
    end
    step();
    step();
    vectors++;
    if (grant_valid !== 1'b1 || grant !== 3'b100) begin
      errors++;
      $display("FAIL rr_wrap got v=%b g=%b want 1 100", grant_valid, grant);
    end
    step();
    vectors++;
    if (pending_any !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain got pa=%b want 0", pending_any);
    end
  endtask

  task automatic test_saturation();
    int cnt;
    do_reset();
    enable = 1'b1; grant_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      press = 3'b001;
      overflow_clr = (k == 8);
      step();
      if (k == 7) begin
        vectors++;
        if (overflow !== 3'b001) begin
          errors++;
          $display("FAIL sat_ovf8 got %b want 001", overflow);
        end
      end
    end
    press = '0; overflow_clr = 1'b0;
    vectors++;
    if (overflow !== 3'b001) begin
      errors++;
      $display("FAIL sat_ovf_set_wins got %b want 001", overflow);
    end
    vectors++;
    if (grant_valid !== 1'b1 || grant !== 3'b001) begin
      errors++;
      $display("FAIL sat_held got v=%b g=%b want 1 001", grant_valid, grant);
    end
    grant_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (grant_valid && grant == 3'b001) cnt++;
      step();
    end
    vectors++;
    if (cnt != 7) begin
      errors++;
      $display("FAIL sat_grants got %0d want 7", cnt);
    end
    vectors++;
    if (pending_any !== 1'b0 || overflow !== 3'b001) begin
      errors++;
      $display("FAIL sat_after got pa=%b ov=%b want 0 001",
               pending_any, overflow);
    end
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    vectors++;
    if (overflow !== 3'b000) begin
      errors++;
      $display("FAIL sat_clr got %b want 000", overflow);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1; grant_ready = 1'b0;
    press = 3'b100;
    step();
    press = '0;
    step();
    enable = 1'b0;
    press = 3'b010;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (grant_valid !== 1'b1 || grant !== 3'b100) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b g=%b want 1 100",
                 k, grant_valid, grant);
      end
      step();
    end
    grant_ready = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (grant_valid !== 1'b0 || pending_any !== 1'b0 || overflow !== 3'b000) begin
        errors++;
        $display("FAIL bp_disabled%0d got v=%b pa=%b ov=%b want 0 0 000",
                 k, grant_valid, pending_any, overflow);
      end
      step();
    end
    press = '0;
    enable = 1'b1;
  endtask

  task automatic test_simultaneous();
    int cnt;
    do_reset();
    enable = 1'b1; grant_ready = 1'b0;
    press = 3'b010;
    for (int k = 0; k < 7; k++) step();
    vectors++;
    if (grant_valid !== 1'b1 || grant !== 3'b010 || overflow !== 3'b000) begin
      errors++;
      $display("FAIL sim_setup got v=%b g=%b ov=%b want 1 010 000",
               grant_valid, grant, overflow);
    end
    grant_ready = 1'b1;
    step();
    press = '0;
    vectors++;
    if (overflow !== 3'b000) begin
      errors++;
      $display("FAIL sim_ovf got %b want 000", overflow);
    end
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (grant_valid && grant == 3'b010) cnt++;
      step();
    end
    vectors++;
    if (cnt != 7) begin
      errors++;
      $display("FAIL sim_count got %0d want 7", cnt);
    end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    enable = 1'b1; grant_ready = 1'b0;
    press = 3'b011;
    step();
    press = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (grant_valid !== 1'b0 || pending_any !== 1'b0 || grant !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset got v=%b pa=%b g=%b want 0 0 000",
               grant_valid, pending_any, grant);
    end
    step();
    vectors++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_after got v=%b want 0", grant_valid);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; press = '0;
    grant_ready = 1'b0; overflow_clr = 1'b0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_saturation();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_offer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
